// File: rtl/hbridge_pkg.sv
// ============================================================================
// Module      : hbridge_pkg
// Description : Shared state encoding, register map and control bit positions
//               for the H-bridge driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hbridge_pkg;

    // STATUS[2:0] exposes this encoding directly, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DEAD  = 3'd1,
        ST_FWD   = 3'd2,
        ST_REV   = 3'd3,
        ST_BRAKE = 3'd4,
        ST_FAULT = 3'd5
    } state_e;

    localparam logic [7:0] c_ADDR_CTRL   = 8'h00;
    localparam logic [7:0] c_ADDR_STATUS = 8'h04;
    localparam logic [7:0] c_ADDR_FCLR   = 8'h08;

    localparam int c_CTRL_EN    = 0;
    localparam int c_CTRL_DIR   = 1;
    localparam int c_CTRL_BRAKE = 2;
    localparam int c_CTRL_W     = 3;

    localparam int c_DEAD_CYCLES_DEF = 1000;

    function automatic state_e target_mode(input logic [c_CTRL_W-1:0] ctrl);
        if (!ctrl[c_CTRL_EN])
            return ST_IDLE;
        else if (ctrl[c_CTRL_BRAKE])
            return ST_BRAKE;
        else if (ctrl[c_CTRL_DIR])
            return ST_REV;
        else
            return ST_FWD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hbridge_sync2.sv
// ============================================================================
// Module      : hbridge_sync2
// Description : Two-flop synchroniser for an active-low level; resets to the
//               inactive (high) value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hbridge_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/hbridge_driver.sv
// ============================================================================
// Module      : hbridge_driver
// Description : APB-controlled H-bridge gate driver with dead-time insertion
//               on every drive-mode change. Optional fault handling (fault_n
//               synchroniser, FAULT state, 0x08 clear) under HBRIDGE_FAULT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hbridge_driver
    import hbridge_pkg::*;
#(
    parameter int DEAD_CYCLES = c_DEAD_CYCLES_DEF
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        pwm_in,
    input  logic        fault_n,
    output logic        hb_in1,
    output logic        hb_in2
);

    // A zero dead time still costs one cycle in DEAD.
    localparam int c_LOAD  = (DEAD_CYCLES < 1) ? 0 : DEAD_CYCLES - 1;
    localparam int c_CNT_W = (c_LOAD < 2) ? 1 : $clog2(c_LOAD + 1);

    logic [c_CTRL_W-1:0] r_ctrl;
    logic [c_CTRL_W-1:0] w_ctrl_eff;
    state_e              r_state, w_state_nxt;
    state_e              r_pend,  w_pend_nxt;
    state_e              w_target;
    logic [c_CNT_W-1:0]  r_cnt,   w_cnt_nxt;
    logic                w_wr;
    logic                w_ctrl_wr;
    logic                w_fault;
    logic                w_clr;
    logic                w_latched;
    logic                w_hb1_nxt, w_hb2_nxt;
    logic                w_unused;

    assign PREADY    = 1'b1;
    assign PSLVERR   = 1'b0;
    assign w_wr      = PSEL & PENABLE & PWRITE;
    assign w_ctrl_wr = w_wr && (PADDR == c_ADDR_CTRL);
    assign w_unused  = &{1'b0, PWDATA[31:c_CTRL_W], fault_n};

    // A CTRL write steers the mode on the same edge that stores it.
    assign w_ctrl_eff = w_ctrl_wr ? PWDATA[c_CTRL_W-1:0] : r_ctrl;
    assign w_target   = target_mode(w_ctrl_eff);

`ifdef HBRIDGE_FAULT_EN
    logic w_fault_n_sync;
    logic r_fault_latched, w_latched_nxt;

    hbridge_sync2 u_fault_sync (
        .clk     (PCLK),
        .rst_n   (PRESETN),
        .i_async (fault_n),
        .o_sync  (w_fault_n_sync)
    );

    assign w_fault   = ~w_fault_n_sync;
    assign w_clr     = w_wr && (PADDR == c_ADDR_FCLR) && PWDATA[0];
    assign w_latched = r_fault_latched;

    always_comb begin
        w_latched_nxt = r_fault_latched;
        if (w_fault)
            w_latched_nxt = 1'b1;
        else if (r_state == ST_FAULT && w_clr)
            w_latched_nxt = 1'b0;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN)
            r_fault_latched <= 1'b0;
        else
            r_fault_latched <= w_latched_nxt;
    end
`else
    assign w_fault   = 1'b0;
    assign w_clr     = 1'b0;
    assign w_latched = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_ctrl  <= '0;
            r_state <= ST_IDLE;
            r_pend  <= ST_IDLE;
            r_cnt   <= '0;
            hb_in1  <= 1'b0;
            hb_in2  <= 1'b0;
        end else begin
            r_ctrl  <= w_ctrl_eff;
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_cnt   <= w_cnt_nxt;
            hb_in1  <= w_hb1_nxt;
            hb_in2  <= w_hb2_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_cnt_nxt   = r_cnt;
        if (w_fault) begin
            w_state_nxt = ST_FAULT;
            w_cnt_nxt   = '0;
        end else if (r_state == ST_FAULT) begin
            if (w_clr)
                w_state_nxt = ST_IDLE;
        end else if (w_target == ST_IDLE) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else if (r_state == ST_DEAD) begin
            // r_pend remembers which mode this dead interval is leading to.
            if (w_target != r_pend) begin
                w_pend_nxt = w_target;
                w_cnt_nxt  = c_CNT_W'(c_LOAD);
            end else if (r_cnt == '0) begin
                w_state_nxt = r_pend;
            end else begin
                w_cnt_nxt = r_cnt - c_CNT_W'(1);
            end
        end else if (w_target != r_state) begin
            w_state_nxt = ST_DEAD;
            w_pend_nxt  = w_target;
            w_cnt_nxt   = c_CNT_W'(c_LOAD);
        end
    end

    always_comb begin
        w_hb1_nxt = 1'b0;
        w_hb2_nxt = 1'b0;
        case (w_state_nxt)
            ST_FWD:   w_hb1_nxt = pwm_in;
            ST_REV:   w_hb2_nxt = pwm_in;
            ST_BRAKE: begin
                w_hb1_nxt = 1'b1;
                w_hb2_nxt = 1'b1;
            end
            default:  ;
        endcase
    end

    always_comb begin
        PRDATA = '0;
        case (PADDR)
            c_ADDR_CTRL:   PRDATA = {{(32-c_CTRL_W){1'b0}}, r_ctrl};
            c_ADDR_STATUS: PRDATA = {27'd0, (r_state == ST_DEAD), w_latched, r_state};
            default:       PRDATA = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_hbridge_driver.sv
// ============================================================================
// Module      : tb_hbridge_driver
// Description : Self-checking bench for hbridge_driver with DEAD_CYCLES=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hbridge_driver;

    logic        PCLK;
    logic        PRESETN;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        pwm_in, fault_n;
    logic        hb_in1, hb_in2;

    int n_checks = 0;
    int n_errors = 0;

    hbridge_driver #(.DEAD_CYCLES(4)) dut (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .pwm_in  (pwm_in),
        .fault_n (fault_n),
        .hb_in1  (hb_in1),
        .hb_in2  (hb_in2)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        bit          wr;
        logic [31:0] wdata;
        logic        pwm;
        logic [1:0]  hb;
        logic [31:0] status;
    } vec_t;

    vec_t vecs [27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        #1;
        d = PRDATA;
        PSEL = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [1:0] hb, input logic [31:0] st);
        logic [31:0] rd;
        check({name, "_hb"}, {30'd0, hb_in1, hb_in2}, {30'd0, hb});
        apb_read(8'h04, rd);
        check({name, "_status"}, rd, st);
    endtask

    initial begin
        logic [31:0] rd;

        // W=write CTRL (2 edges, checked after access edge), else one tick.
        vecs[0]  = '{1'b1, 32'h1, 1'b1, 2'b00, 32'h11};
        vecs[1]  = '{1'b0, 32'h0, 1'b1, 2'b00, 32'h11};
        vecs[2]  = '{1'b0, 32'h0, 1'b1, 2'b00, 32'h11};
        vecs[3]  = '{1'b0, 32'h0, 1'b1, 2'b00, 32'h11};
        vecs[4]  = '{1'b0, 32'h0, 1'b1, 2'b10, 32'h02};
        vecs[5]  = '{1'b0, 32'h0, 1'b0, 2'b00, 32'h02};
        vecs[6]  = '{1'b0, 32'h0, 1'b1, 2'b10, 32'h02};
        vecs[7]  = '{1'b1, 32'h3, 1'b1, 2'b00, 32'h11};
        vecs[8]  = '{1'b0, 32'h0, 1'b1, 2'b00, 32'h11};
        vecs[9]  = '{1'b0, 32'h0, 1'b1, 2'b00, 32'h11};
        vecs[10] = '{1'b0, 32'h0, 1'b1, 2'b00, 32'h11};
        vecs[11] = '{1'b0, 32'h0, 1'b1, 2'b01, 32'h03};
        vecs[12] = '{1'b0, 32'h0, 1'b0, 2'b00, 32'h03};
        vecs[13] = '{1'b0, 32'h0, 1'b1, 2'b01, 32'h03};
        vecs[14] = '{1'b1, 32'h5, 1'b1, 2'b00, 32'h11};
        vecs[15] = '{1'b0, 32'h0, 1'b1, 2'b00, 32'h11};
        vecs[16] = '{1'b0, 32'h0, 1'b1, 2'b00, 32'h11};
        vecs[17] = '{1'b0, 32'h0, 1'b1, 2'b00, 32'h11};
        vecs[18] = '{1'b0, 32'h0, 1'b1, 2'b11, 32'h04};
        vecs[19] = '{1'b1, 32'h0, 1'b1, 2'b00, 32'h00};
        vecs[20] = '{1'b1, 32'h1, 1'b1, 2'b00, 32'h11};
        vecs[21] = '{1'b0, 32'h0, 1'b1, 2'b00, 32'h11};
        vecs[22] = '{1'b1, 32'h3, 1'b1, 2'b00, 32'h11};
        vecs[23] = '{1'b0, 32'h0, 1'b1, 2'b00, 32'h11};
        vecs[24] = '{1'b0, 32'h0, 1'b1, 2'b00, 32'h11};
        vecs[25] = '{1'b0, 32'h0, 1'b1, 2'b00, 32'h11};
        vecs[26] = '{1'b0, 32'h0, 1'b1, 2'b01, 32'h03};

        PRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 8'h00; PWDATA = 32'h0; pwm_in = 1'b0; fault_n = 1'b1;
        #12;
        check("reset_hb", {30'd0, hb_in1, hb_in2}, 32'h0);
        apb_read(8'h00, rd); check("reset_ctrl", rd, 32'h0);
        apb_read(8'h04, rd); check("reset_status", rd, 32'h0);
        check("pready_pslverr", {30'd0, PREADY, PSLVERR}, 32'h2);
        PRESETN = 1'b1;
        tick();

        for (int i = 0; i < 27; i++) begin
            pwm_in = vecs[i].pwm;
            if (vecs[i].wr)
                apb_write(8'h00, vecs[i].wdata);
            else
                tick();
            check_out($sformatf("vec%0d", i), vecs[i].hb, vecs[i].status);
        end

        // Back to FWD: REV -> DEAD (4 cycles) -> FWD.
        pwm_in = 1'b1;
        apb_write(8'h00, 32'h1);
        for (int k = 0; k < 4; k++) tick();
        check_out("to_fwd", 2'b10, 32'h02);

`ifdef HBRIDGE_FAULT_EN
        fault_n = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check_out("fault_entry", 2'b00, 32'h0D);
        apb_write(8'h08, 32'h1);
        check_out("clr_while_fault", 2'b00, 32'h0D);
        apb_write(8'h00, 32'h3);
        apb_read(8'h00, rd); check("ctrl_in_fault", rd, 32'h3);
        check_out("ctrl_in_fault", 2'b00, 32'h0D);
        apb_write(8'h00, 32'h0);
        fault_n = 1'b1;
        tick(); tick();
        check_out("fault_gone_no_clr", 2'b00, 32'h0D);
        apb_write(8'h08, 32'h1);
        check_out("fault_cleared", 2'b00, 32'h00);
`else
        fault_n = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check_out("fault_ignored", 2'b10, 32'h02);
        apb_write(8'h08, 32'h1);
        check_out("clr_ignored", 2'b10, 32'h02);
        fault_n = 1'b1;
        apb_write(8'h00, 32'h0);
        check_out("disable", 2'b00, 32'h00);
`endif

        // Writes to unmapped addresses are ignored; unmapped reads return 0.
        apb_write(8'h0C, 32'h1);
        tick();
        check_out("bad_addr_wr", 2'b00, 32'h00);
        apb_read(8'h00, rd); check("bad_addr_ctrl", rd, 32'h0);

        // Reset mid-DEAD discards everything.
        apb_write(8'h00, 32'h1);
        apb_read(8'h0C, rd); check("unmapped_read", rd, 32'h0);
        tick();
        check_out("pre_reset_dead", 2'b00, 32'h11);
        PRESETN = 1'b0;
        #1;
        check("rst_async_hb", {30'd0, hb_in1, hb_in2}, 32'h0);
        apb_read(8'h00, rd); check("rst_ctrl", rd, 32'h0);
        apb_read(8'h04, rd); check("rst_status", rd, 32'h0);
        #1;
        PRESETN = 1'b1;
        tick(); tick();
        check_out("post_reset_idle", 2'b00, 32'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hbridge_driver.md
HBRIDGE_DRIVER -- requirements
Module: hbridge_driver

Interface
REQ-001 SHALL have parameter DEAD_CYCLES, default 1000, PCLK cycles both bridge inputs are held low on any drive-mode change.
REQ-002 SHALL have ports PCLK in 1 (sole clock) and PRESETN in 1 (reset: one clock; reset is asynchronous and active-low).
REQ-003 SHALL have APB ports PSEL, PENABLE, PWRITE in 1; PADDR in 8; PWDATA in 32; PRDATA out 32; PREADY out 1 (tied 1); PSLVERR out 1 (tied 0).
REQ-004 SHALL have pwm_in in 1: PWM waveform from the upstream PWM stage, same clock domain.
REQ-005 SHALL have fault_n in 1: asynchronous active-low driver fault.
REQ-006 SHALL have hb_in1 and hb_in2 out 1: H-bridge gate inputs.

Function
REQ-007 SHALL decode APB write (PSEL&PENABLE&PWRITE): 0x00 CTRL{bit0 enable, bit1 dir (0=fwd), bit2 brake}; 0x08 write bit0=1 clears fault; other addresses are ignored.
REQ-008 SHALL return PRDATA combinationally: 0x00 CTRL; 0x04 STATUS{[2:0] state, bit3 fault_latched, bit4 dead_active}; all other addresses 0.
REQ-009 SHALL implement states IDLE, DEAD, FWD, REV, BRAKE, FAULT.
REQ-010 Target mode SHALL be: enable=0 -> IDLE; brake=1 -> BRAKE; otherwise dir selects FWD/REV.
REQ-011 From IDLE, FWD, REV or BRAKE, a target differing from the current state (other than IDLE) SHALL enter DEAD with the counter loaded to DEAD_CYCLES-1.
REQ-012 DEAD SHALL decrement each cycle and enter the target at count 0; a target change during DEAD SHALL reload the counter.
REQ-013 enable=0 SHALL enter IDLE on the next edge from any non-FAULT state, with no dead time.
REQ-014 Outputs SHALL be registered, 1-cycle latency: IDLE/DEAD/FAULT 0/0; FWD pwm_in/0; REV 0/pwm_in; BRAKE 1/1.
REQ-015 hb_in1 and hb_in2 SHALL never both be 1 outside BRAKE, and BRAKE SHALL be entered only through DEAD.
REQ-016 Synchronised fault_n low SHALL enter FAULT from any state and set fault_latched; fault SHALL take priority over a simultaneous CTRL write, and that write still updates CTRL.
REQ-017 FAULT SHALL exit to IDLE only when a clear is written while synchronised fault_n is high; a clear while fault persists SHALL be ignored.
REQ-018 DEAD_CYCLES=0 SHALL be treated as 1.

Reset
REQ-019 PRESETN low SHALL asynchronously force: CTRL=0, state IDLE, counter 0, fault_latched 0, hb_in1=hb_in2=0, synchroniser flops 1.
REQ-020 Reset asserted mid-DEAD or mid-FAULT SHALL discard all progress.

Configuration
REQ-021 Macro HBRIDGE_FAULT_EN SHALL include the fault_n synchroniser, the FAULT state and the 0x08 clear register.
REQ-022 Without HBRIDGE_FAULT_EN, fault_n SHALL be ignored, FAULT SHALL be unreachable, STATUS bit3 SHALL read 0, and 0x08 writes SHALL be ignored.

Structure
REQ-023 Package hbridge_pkg SHALL hold the state encoding, the register offsets (0x00/0x04/0x08), CTRL bit positions and the DEAD_CYCLES default.
REQ-024 The fault_n 2-flop synchroniser SHALL be sub-module hbridge_sync2 (async reset to 1); all other logic stays in hbridge_driver.

Verification (bench DEAD_CYCLES=4)
REQ-025 Write CTRL=0x1 from IDLE -> 4 cycles 0/0, then hb_in1 follows pwm_in one cycle late, hb_in2=0.
REQ-026 In FWD, write CTRL=0x3 -> 0/0 for exactly 4 cycles, then hb_in2 follows pwm_in, hb_in1=0; no cycle with both outputs 1.
REQ-027 In REV, write CTRL=0x5 -> DEAD for 4 cycles, then 1/1; write CTRL=0x0 -> 0/0 on the next cycle.
REQ-028 In DEAD at count 1, write a new dir -> counter reloads and DEAD lasts 4 more cycles.
REQ-029 With HBRIDGE_FAULT_EN: drive fault_n=0 in FWD -> 0/0 within 3 cycles, STATUS=0x0D; clear while fault_n=0 -> no change; fault_n=1 then clear -> IDLE, STATUS bit3=0.
REQ-030 Assert PRESETN mid-DEAD -> outputs 0/0 immediately; PRDATA at 0x00 and 0x04 reads 0.
